// File: rtl/turbo_punct_serializer.sv
// Turbo encoder output stage: muxes systematic/parity words into an LSB-first serial stream.
// Rate 1/3 by default; define TURBO_PUNCTURE_EN for rate 1/2 (alternating par1/par2).
module turbo_punct_serializer #(
  parameter int WORD_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] sys_in,
  input  logic [WORD_W-1:0] par1_in,
  input  logic [WORD_W-1:0] par2_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_bit,
  output logic              out_sof,
  output logic              out_eof,
  output logic              busy
);

  localparam int IW = $clog2(WORD_W);
`ifdef TURBO_PUNCTURE_EN
  localparam logic [1:0] LAST_PH = 2'd1;
`else
  localparam logic [1:0] LAST_PH = 2'd2;
`endif

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            state, state_n;
  logic [WORD_W-1:0] sys_q, p1_q, p2_q;
  logic [IW-1:0]     idx, idx_n;
  logic [1:0]        ph, ph_n;
  logic              sel_bit;
  logic              fire;
  logic              last_xfer;
  logic              accept;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
      ph    <= '0;
      sys_q <= '0;
      p1_q  <= '0;
      p2_q  <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      ph    <= ph_n;
      if (accept) begin
        sys_q <= sys_in;
        p1_q  <= par1_in;
        p2_q  <= par2_in;
      end
    end
  end

  // Punctured build reuses phase 1 for whichever parity survives at this index.
  always_comb begin
    sel_bit = 1'b0;
    case (ph)
      2'd0: sel_bit = sys_q[idx];
`ifdef TURBO_PUNCTURE_EN
      2'd1: sel_bit = idx[0] ? p2_q[idx] : p1_q[idx];
`else
      2'd1: sel_bit = p1_q[idx];
      2'd2: sel_bit = p2_q[idx];
`endif
      default: sel_bit = 1'b0;
    endcase
  end

  always_comb begin
    state_n   = state;
    idx_n     = idx;
    ph_n      = ph;
    out_valid = (state == SHIFT);
    busy      = (state == SHIFT);
    out_bit   = out_valid & sel_bit;
    out_sof   = out_valid && (idx == '0) && (ph == 2'd0);
    out_eof   = out_valid && (idx == IW'(WORD_W - 1)) && (ph == LAST_PH);
    fire      = out_valid && out_ready;
    last_xfer = fire && out_eof;
    in_ready  = (state == IDLE) || last_xfer;
    accept    = in_valid && in_ready;

    // A new block on the eof edge restarts the counters without an idle cycle.
    if (accept) begin
      state_n = SHIFT;
      idx_n   = '0;
      ph_n    = 2'd0;
    end else if (last_xfer) begin
      state_n = IDLE;
      idx_n   = '0;
      ph_n    = 2'd0;
    end else if (fire) begin
      if (ph == LAST_PH) begin
        ph_n  = 2'd0;
        idx_n = idx + IW'(1);
      end else begin
        ph_n  = ph + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_turbo_punct_serializer.sv
// Self-checking bench for turbo_punct_serializer: table vectors plus scoreboarded corner sequences.
// Expected streams follow TURBO_PUNCTURE_EN when the bench is built with it defined.
module tb_turbo_punct_serializer;

`ifdef TURBO_PUNCTURE_EN
  localparam int NBITS = 16;
`else
  localparam int NBITS = 24;
`endif

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] sys_in, par1_in, par2_in;
  logic       out_valid;
  logic       out_ready;
  logic       out_bit;
  logic       out_sof;
  logic       out_eof;
  logic       busy;

  turbo_punct_serializer #(.WORD_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sys_in    (sys_in),
    .par1_in   (par1_in),
    .par2_in   (par2_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bit   (out_bit),
    .out_sof   (out_sof),
    .out_eof   (out_eof),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  sys;
    logic [7:0]  p1;
    logic [7:0]  p2;
    logic [23:0] exp13;
    logic [15:0] exp12;
  } vec_t;

  typedef struct {
    logic b;
    logic sof;
    logic eof;
  } sb_t;

  vec_t tbl[4];
  sb_t  sb[$];
  int   checkCount = 0;
  int   passCount  = 0;
  logic monEn      = 1'b0;
  logic randOn     = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [23:0] modelStream(input logic [7:0] s, input logic [7:0] a, input logic [7:0] b);
    logic [23:0] r;
    int k;
    r = '0;
    k = 0;
    for (int i = 0; i < 8; i++) begin
      r[k] = s[i]; k++;
`ifdef TURBO_PUNCTURE_EN
      r[k] = (i % 2 == 0) ? a[i] : b[i]; k++;
`else
      r[k] = a[i]; k++;
      r[k] = b[i]; k++;
`endif
    end
    return r;
  endfunction

  function automatic logic [23:0] tblExp(input int i);
`ifdef TURBO_PUNCTURE_EN
    return {8'h00, tbl[i].exp12};
`else
    return tbl[i].exp13;
`endif
  endfunction

  task automatic pushStream(input logic [23:0] s);
    sb_t e;
    for (int k = 0; k < NBITS; k++) begin
      e.b   = s[k];
      e.sof = (k == 0);
      e.eof = (k == NBITS - 1);
      sb.push_back(e);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic applyStimulus(input logic [7:0] s, input logic [7:0] a, input logic [7:0] b,
                               input logic [23:0] stream);
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    sys_in   = s;
    par1_in  = a;
    par2_in  = b;
    for (int c = 0; c < 500 && !done; c++) begin
      @(negedge clk);
      if (in_ready) begin
        pushStream(stream);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (!done) checkOutput("accept_timeout", 0, 1);
  endtask

  task automatic dropValid();
    in_valid = 1'b0;
  endtask

  task automatic waitIdle();
    int c;
    for (c = 0; c < 600; c++) begin
      @(negedge clk);
      if (sb.size() == 0) break;
    end
    if (c == 600) checkOutput("drain_timeout", sb.size(), 0);
    @(negedge clk);
    checkOutput("idle_state", {out_valid, in_ready, busy, out_sof, out_eof}, 5'b01000);
    @(posedge clk); #1;
  endtask

  // Compares every presented bit (stalled or not) against the head of the scoreboard.
  always @(negedge clk) begin
    if (monEn && out_valid) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_bit", {31'd0, out_valid}, 0);
      end else begin
        checkOutput("stream_bit", {29'd0, out_bit, out_sof, out_eof},
                    {29'd0, sb[0].b, sb[0].sof, sb[0].eof});
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  always @(posedge clk) begin
    #2;
    if (randOn) out_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: got timeout, required $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] rs, ra, rb;

    tbl[0] = '{sys: 8'hD5, p1: 8'h3C, p2: 8'hA0, exp13: 24'hA734C1, exp12: 16'hDB31};
    tbl[1] = '{sys: 8'h01, p1: 8'h00, p2: 8'h00, exp13: 24'h000001, exp12: 16'h0001};
    tbl[2] = '{sys: 8'h00, p1: 8'hFF, p2: 8'h00, exp13: 24'h492492, exp12: 16'h2222};
    tbl[3] = '{sys: 8'h00, p1: 8'h00, p2: 8'hFF, exp13: 24'h924924, exp12: 16'h8888};

    reset     = 1'b1;
    in_valid  = 1'b0;
    sys_in    = '0;
    par1_in   = '0;
    par2_in   = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("reset_state", {out_valid, in_ready, busy, out_bit, out_sof, out_eof}, 6'b010000);
    monEn = 1'b1;
    @(posedge clk); #1;

    // Table vectors: single blocks with out_ready held high.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(tbl[i].sys, tbl[i].p1, tbl[i].p2, tblExp(i));
      dropValid();
      @(negedge clk);
      checkOutput("sof_latency", {out_valid, out_sof, busy}, 3'b111);
      @(posedge clk); #1;
      waitIdle();
    end

    // Back-to-back: second block accepted on first block's eof edge.
    applyStimulus(8'hD5, 8'h3C, 8'hA0, modelStream(8'hD5, 8'h3C, 8'hA0));
    applyStimulus(8'h5A, 8'hC3, 8'h0F, modelStream(8'h5A, 8'hC3, 8'h0F));
    dropValid();
    @(negedge clk);
    checkOutput("b2b_no_gap", {out_valid, out_sof}, 2'b11);
    @(posedge clk); #1;
    waitIdle();

    // Random backpressure over several consecutive blocks.
    randOn = 1'b1;
    for (int n = 0; n < 3; n++) begin
      rs = 8'($urandom); ra = 8'($urandom); rb = 8'($urandom);
      applyStimulus(rs, ra, rb, modelStream(rs, ra, rb));
    end
    applyStimulus(8'hD5, 8'h3C, 8'hA0, tblExp(0));
    dropValid();
    waitIdle();
    randOn    = 1'b0;
    out_ready = 1'b1;

    // in_valid pulse mid-block must be ignored.
    applyStimulus(8'hD5, 8'h3C, 8'hA0, tblExp(0));
    dropValid();
    repeat (5) @(posedge clk);
    #1;
    in_valid = 1'b1; sys_in = 8'hFF; par1_in = 8'hFF; par2_in = 8'hFF;
    @(negedge clk);
    checkOutput("mid_in_ready", {31'd0, in_ready}, 0);
    @(posedge clk); #1;
    dropValid();
    waitIdle();

    // Reset mid-block discards the block.
    applyStimulus(8'hD5, 8'h3C, 8'hA0, tblExp(0));
    dropValid();
    repeat (9) @(posedge clk);
    #1;
    monEn = 1'b0;
    reset = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("reset_mid_block", {out_valid, in_ready, busy, out_sof}, 4'b0100);
    monEn = 1'b1;
    @(posedge clk); #1;
    applyStimulus(tbl[1].sys, tbl[1].p1, tbl[1].p2, tblExp(1));
    dropValid();
    waitIdle();

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
